// File: rtl/mem_arbiter_pkg.sv
// Shared widths, watchdog default, FSM/owner encodings and memory request/response structs.
// Imported by the arbiter top and its pending-slot sub-module.
package mem_arbiter_pkg;

  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 32;
  localparam int STRB_W          = 4;
  localparam int TIMEOUT_DEFAULT = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // Request heading to the memory port; in a slot, valid means "slot full".
  typedef struct packed {
    logic              valid;
    logic              instr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_in_type;

  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              error;
  } mem_out_type;

endpackage

// File: rtl/mem_arbiter_slot.sv
// One-deep pending-request register for a single requester: loads on a request strobe,
// clears when granted; strobes arriving while full or in flight are dropped.
module mem_arbiter_slot
  import mem_arbiter_pkg::*;
#(
  parameter bit is_instr = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  input  logic              clear,
  input  logic              in_flight,
  output mem_in_type        slot
);

  logic accept;
  assign accept = req_valid && !slot.valid && !in_flight;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot <= '0;
    end else if (accept) begin
      slot.valid <= 1'b1;
      slot.instr <= is_instr;
      slot.addr  <= req_addr;
      slot.wdata <= req_wdata;
      slot.wstrb <= is_instr ? '0 : req_wstrb;
    end else if (clear) begin
      slot.valid <= 1'b0;
    end
  end

  // A requester may only have one request outstanding at a time.
  assert property (@(posedge clock) disable iff (reset) !(req_valid && (slot.valid || in_flight)))
    else $error("mem_arbiter_slot: request strobe while slot full or transaction in flight");

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store, one transaction
// outstanding, combinational response routing to the owner, watchdog-terminated hangs.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int timeout_cycles = TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              imem_valid,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic              imem_ready,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_error,
  input  logic              dmem_valid,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [STRB_W-1:0] dmem_wstrb,
  output logic              dmem_ready,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_error,
  output logic              mem_valid,
  output logic              mem_instr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(timeout_cycles);

  arb_state_e       state, state_nxt;
  owner_e           owner, owner_nxt;
  owner_e           last_grant, last_grant_nxt;
  logic [CNT_W-1:0] wdog, wdog_nxt;

  mem_in_type  islot, dslot, mem_req;
  mem_out_type rsp;
  logic        grant_data, expire, clr_i, clr_d;
  logic        inflight_i, inflight_d;

  mem_arbiter_slot #(.is_instr(1'b1)) u_islot (
    .clock     (clock),
    .reset     (reset),
    .req_valid (imem_valid),
    .req_addr  (imem_addr),
    .req_wdata ('0),
    .req_wstrb ('0),
    .clear     (clr_i),
    .in_flight (inflight_i),
    .slot      (islot)
  );

  mem_arbiter_slot #(.is_instr(1'b0)) u_dslot (
    .clock     (clock),
    .reset     (reset),
    .req_valid (dmem_valid),
    .req_addr  (dmem_addr),
    .req_wdata (dmem_wdata),
    .req_wstrb (dmem_wstrb),
    .clear     (clr_d),
    .in_flight (inflight_d),
    .slot      (dslot)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_INSTR;
      last_grant <= OWN_INSTR;
      wdog       <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      wdog       <= wdog_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    wdog_nxt       = wdog;
    mem_req        = '0;
    rsp            = '0;
    expire         = 1'b0;
    clr_i          = 1'b0;
    clr_d          = 1'b0;
    // On a tie the requester not granted last time goes first.
    grant_data     = dslot.valid && (!islot.valid || last_grant == OWN_INSTR);
    case (state)
      IDLE: begin
        if (islot.valid || dslot.valid) begin
          mem_req        = grant_data ? dslot : islot;
          owner_nxt      = grant_data ? OWN_DATA : OWN_INSTR;
          last_grant_nxt = grant_data ? OWN_DATA : OWN_INSTR;
          clr_d          = grant_data;
          clr_i          = !grant_data;
          wdog_nxt       = '0;
          state_nxt      = BUSY;
        end
      end
      BUSY: begin
        expire    = (wdog == CNT_W'(timeout_cycles - 1)) && !mem_ready;
        rsp.ready = mem_ready || expire;
        rsp.error = expire;
        rsp.rdata = mem_ready ? mem_rdata : '0;
        wdog_nxt  = wdog + 1'b1;
        if (rsp.ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The completing requester may re-request in its response cycle.
  assign inflight_i = (state == BUSY) && (owner == OWN_INSTR) && !rsp.ready;
  assign inflight_d = (state == BUSY) && (owner == OWN_DATA) && !rsp.ready;

  assign mem_valid = mem_req.valid;
  assign mem_instr = mem_req.instr;
  assign mem_addr  = mem_req.addr;
  assign mem_wdata = mem_req.wdata;
  assign mem_wstrb = mem_req.wstrb;

  assign imem_ready = rsp.ready && (owner == OWN_INSTR);
  assign imem_rdata = (owner == OWN_INSTR) ? rsp.rdata : '0;
  assign imem_error = rsp.error && (owner == OWN_INSTR);
  assign dmem_ready = rsp.ready && (owner == OWN_DATA);
  assign dmem_rdata = (owner == OWN_DATA) ? rsp.rdata : '0;
  assign dmem_error = rsp.error && (owner == OWN_DATA);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: queue-based reference model of pending requests,
// round-robin grants, watchdog expiry and response routing, plus streaming and reset scenarios.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_valid, dmem_valid, mem_ready;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, mem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        imem_ready, imem_error, dmem_ready, dmem_error;
  logic [31:0] imem_rdata, dmem_rdata;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  mem_arbiter #(.timeout_cycles(TO)) dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_error(imem_error),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_error(dmem_error),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct { bit instr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } req_t;
  typedef struct { bit d; logic [31:0] rdata; bit err; } rsp_t;

  req_t pi[$], pd[$];
  rsp_t exp_q[$];

  int tests = 0, fails = 0;
  bit m_busy = 0, m_owner_d = 0, last_d = 0;
  int m_cycles = 0;
  int rsp_i = 0, rsp_d = 0;
  bit g_on = 0, g_prev = 0;
  int g_cnt = 0, g_d = 0, alt_bad = 0;

  bit hold = 1, resp_en = 1, mon_en = 0;
  int rate = 0, max_dly = 0;
  bit i_out = 0, d_out = 0;
  bit r_pend = 0;
  int r_dly = 0;

  wire [137:0] all_out = {mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                          imem_ready, imem_rdata, imem_error, dmem_ready, dmem_rdata, dmem_error};

  // Requesters: one outstanding request each, allowed to re-request in the response cycle.
  always @(posedge clock) begin
    #2;
    if (imem_ready) i_out = 0;
    if (dmem_ready) d_out = 0;
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    if (!hold && !reset) begin
      if (!i_out && $urandom_range(99) < rate) begin
        imem_valid = 1'b1;
        imem_addr  = $urandom & 32'hFFFF_FFFC;
        i_out      = 1;
      end
      if (!d_out && $urandom_range(99) < rate) begin
        dmem_valid = 1'b1;
        dmem_addr  = $urandom & 32'hFFFF_FFFC;
        dmem_wdata = $urandom;
        dmem_wstrb = 4'($urandom_range(15));
        d_out      = 1;
      end
    end
  end

  // Memory model: answers after a random delay; long delays trip the watchdog.
  always @(posedge clock) begin
    #1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    if (reset) r_pend = 0;
    else if (r_pend && resp_en) begin
      if (r_dly == 0) begin
        mem_ready = 1'b1;
        mem_rdata = $urandom;
        r_pend    = 0;
      end else r_dly--;
    end
  end

  always @(negedge clock) begin
    if (mem_valid && !reset) begin
      r_pend = 1;
      r_dly  = $urandom_range(max_dly);
    end
  end

  // Reference model and scoreboard, evaluated once per cycle away from the active edge.
  always @(negedge clock) begin
    bit busy0, exp_mv, win_d;
    req_t r;
    rsp_t e;
    logic [67:0] got_r, exp_r;
    logic [69:0] got_m, exp_m;
    if (!reset && mon_en) begin
      busy0 = m_busy;
      if (busy0) begin
        m_cycles++;
        if (mem_ready) begin
          e.d = m_owner_d; e.rdata = mem_rdata; e.err = 0;
          exp_q.push_back(e); m_busy = 0;
        end else if (m_cycles == TO - 1) begin
          e.d = m_owner_d; e.rdata = 32'h0; e.err = 1;
          exp_q.push_back(e); m_busy = 0;
        end
      end
      if (imem_ready || dmem_ready || exp_q.size() > 0) begin
        tests++;
        got_r = {imem_ready, imem_rdata, imem_error, dmem_ready, dmem_rdata, dmem_error};
        exp_r = '0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (e.d) exp_r = {1'b0, 32'h0, 1'b0, 1'b1, e.rdata, e.err};
          else     exp_r = {1'b1, e.rdata, e.err, 1'b0, 32'h0, 1'b0};
        end
        if (got_r !== exp_r) begin
          fails++;
          $display("FAIL rsp @%0t: got %h required %h", $time, got_r, exp_r);
        end
        if (imem_ready) rsp_i++;
        if (dmem_ready) rsp_d++;
      end
      exp_mv = !busy0 && (pi.size() > 0 || pd.size() > 0);
      if (exp_mv || mem_valid) begin
        tests++;
        exp_m = '0;
        if (exp_mv) begin
          win_d = pd.size() > 0 && (pi.size() == 0 || !last_d);
          if (win_d) r = pd.pop_front();
          else       r = pi.pop_front();
          exp_m = {1'b1, r.instr, r.addr, r.wdata, r.wstrb};
          m_busy = 1; m_cycles = -1; m_owner_d = win_d; last_d = win_d;
          if (g_on) begin
            if (g_cnt > 0 && win_d == g_prev) alt_bad++;
            g_prev = win_d; g_cnt++;
            if (win_d) g_d++;
          end
        end
        got_m = {mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb};
        if (got_m !== exp_m) begin
          fails++;
          $display("FAIL issue @%0t: got %h required %h", $time, got_m, exp_m);
        end
      end
      if (imem_valid) begin
        r.instr = 1; r.addr = imem_addr; r.wdata = 32'h0; r.wstrb = 4'h0;
        pi.push_back(r);
      end
      if (dmem_valid) begin
        r.instr = 0; r.addr = dmem_addr; r.wdata = dmem_wdata; r.wstrb = dmem_wstrb;
        pd.push_back(r);
      end
    end
  end

  task automatic check(input string name, input longint got, input longint req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  initial begin
    int ri0, rd0;
    bit drained;
    reset = 1'b1;
    imem_valid = 0; dmem_valid = 0; mem_ready = 0; mem_rdata = 0;
    imem_addr = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
    repeat (3) @(posedge clock);
    #3;
    check("reset_outputs_zero", longint'(all_out != '0), 0);
    @(negedge clock);
    #2 reset = 1'b0;
    mon_en = 1;

    // Mixed random traffic: ties, late responses, timeouts, capture during completion.
    hold = 0; rate = 40; max_dly = 11;
    repeat (800) @(posedge clock);

    // Streaming: both requesters always re-request; grants must alternate.
    rate = 100; max_dly = 2;
    repeat (20) @(posedge clock);
    g_on = 1;
    for (int k = 0; k < 2000 && g_cnt < 100; k++) @(posedge clock);
    g_on = 0;
    check("stream_grants", g_cnt, 100);
    check("stream_alternation_breaks", alt_bad, 0);
    check("stream_data_grants", g_d, 50);

    // Reset in the middle of a data transaction.
    hold = 1;
    drained = 0;
    for (int k = 0; k < 200 && !drained; k++) begin
      @(posedge clock);
      drained = !m_busy && pi.size() == 0 && pd.size() == 0 && !i_out && !d_out;
    end
    check("drain_before_reset", drained, 1);
    resp_en = 0;
    #3;
    dmem_valid = 1'b1; dmem_addr = 32'h0100_0000; dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'hF;
    @(posedge clock);
    #3 dmem_valid = 1'b0;
    @(posedge clock);
    #3;
    check("busy_before_reset", m_busy, 1);
    reset = 1'b1;
    #1;
    check("mid_reset_outputs_zero", longint'(all_out != '0), 0);
    m_busy = 0; last_d = 0; pi.delete(); pd.delete(); exp_q.delete();
    i_out = 0; d_out = 0; r_pend = 0;
    @(negedge clock);
    #2 reset = 1'b0;
    resp_en = 1;
    ri0 = rsp_i; rd0 = rsp_d;
    @(posedge clock);
    #3 imem_valid = 1'b1; imem_addr = 32'h0000_0100;
    @(posedge clock);
    #3 imem_valid = 1'b0;
    for (int k = 0; k < 30 && rsp_i == ri0; k++) @(posedge clock);
    repeat (12) @(posedge clock);
    check("post_reset_fetch_rsp", rsp_i - ri0, 1);
    check("pre_reset_owner_rsp", rsp_d - rd0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
